// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter: splits long INCR AXI4 read bursts into sub-bursts of at most MAX_BEATS beats.
module axi_rd_burst_splitter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_WIDTH-1:0]   s_arid,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic [7:0]            s_arlen,
  input  logic [2:0]            s_arsize,
  input  logic [1:0]            s_arburst,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [ID_WIDTH-1:0]   s_rid,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rlast,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ID_WIDTH-1:0]   m_arid,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [ID_WIDTH-1:0]   m_rid,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rlast,
  input  logic                  m_rvalid,
  output logic                  m_rready
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT_R = 2'd2;
  localparam logic [8:0] MB     = 9'(MAX_BEATS);
  logic [1:0]            r_state;
  logic                  r_rdy;
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [8:0]            r_rem;
  logic                  w_incr;
  logic                  w_final;
  logic                  w_sub_done;
  logic [8:0]            w_beats;
  logic [ADDR_WIDTH-1:0] w_next;
  assign w_incr     = r_burst == 2'b01;
  assign w_beats    = w_incr ? (r_rem > MB ? MB : r_rem) : {1'b0, r_len} + 9'd1;
  assign w_final    = !w_incr || r_rem <= MB;
  assign w_next     = ((r_addr >> r_size) << r_size) + (ADDR_WIDTH'(w_beats) << r_size);
  assign w_sub_done = r_state == WAIT_R && m_rvalid && s_rready && m_rlast;
  // r_rdy holds s_arready low until the first clock edge after reset release
  assign s_arready = r_state == IDLE && r_rdy;
  assign m_arvalid = r_state == ISSUE;
  assign m_arid    = r_id;
  assign m_araddr  = r_addr;
  assign m_arlen   = 8'(w_beats - 9'd1);
  assign m_arsize  = r_size;
  assign m_arburst = r_burst;
  assign m_rready  = r_state == WAIT_R && s_rready;
  assign s_rvalid  = r_state == WAIT_R && m_rvalid;
  assign s_rid     = r_id;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rlast   = r_state == WAIT_R && m_rlast && w_final;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_rem   <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (s_arvalid && s_arready) begin
        r_id    <= s_arid;
        r_addr  <= s_araddr;
        r_len   <= s_arlen;
        r_size  <= s_arsize;
        r_burst <= s_arburst;
        r_rem   <= {1'b0, s_arlen} + 9'd1;
        r_state <= ISSUE;
      end
      if (r_state == ISSUE && m_arready) r_state <= WAIT_R;
      // the sub-burst ends on m_rlast even if it arrives early
      if (w_sub_done) begin
        r_state <= w_final ? IDLE : ISSUE;
        r_addr  <= w_next;
        r_rem   <= r_rem - w_beats;
      end
    end
endmodule

// File: tb/tb_axi_rd_burst_splitter.sv
// tb_axi_rd_burst_splitter: randomized bench with a transaction-level reference for the read burst splitter.
module tb_axi_rd_burst_splitter;
  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [3:0]  s_arid = '0;
  logic [31:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic [2:0]  s_arsize = '0;
  logic [1:0]  s_arburst = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [3:0]  s_rid;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rlast;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic [3:0]  m_arid;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic        m_arvalid;
  logic        m_arready = 1'b0;
  logic [3:0]  m_rid = '0;
  logic [63:0] m_rdata = '0;
  logic [1:0]  m_rresp = '0;
  logic        m_rlast = 1'b0;
  logic        m_rvalid = 1'b0;
  logic        m_rready;

  axi_rd_burst_splitter #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .MAX_BEATS(16)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
    .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0, n_err = 0, cyc = 0, rx_cnt = 0, rlast_cyc = 0;
  logic [127:0] exp_ar[$];
  logic [127:0] exp_r[$];
  logic        ar_hs_n = 1'b0, r_hs_n = 1'b0;
  logic [31:0] snap_addr = '0;
  logic [7:0]  snap_len = '0;
  logic        sl_active = 1'b0;
  logic [31:0] sl_addr = '0;
  int          sl_n = 0, sl_b = 0;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nstep;
    @(negedge aclk);
    #1;
  endtask

  always @(posedge aclk) cyc++;

  // monitors: downstream AR and upstream R beats against the reference queues
  always @(negedge aclk) begin
    ar_hs_n   = aresetn && m_arvalid && m_arready;
    r_hs_n    = aresetn && m_rvalid && m_rready;
    snap_addr = m_araddr;
    snap_len  = m_arlen;
    if (ar_hs_n) begin
      if (exp_ar.size() == 0) chk("ar_unexpected", 128'(1), 128'(0));
      else chk("ar", 128'({m_arid, m_araddr, m_arlen, m_arsize, m_arburst}), exp_ar.pop_front());
    end
    if (aresetn && s_rvalid && s_rready) begin
      rx_cnt++;
      if (s_rlast) rlast_cyc = cyc;
      if (exp_r.size() == 0) chk("r_unexpected", 128'(1), 128'(0));
      else chk("r", 128'({s_rid, s_rdata, s_rresp, s_rlast}), exp_r.pop_front());
    end
    if (aresetn && !s_rready) chk("rready_gate", 128'(m_rready), 128'(0));
  end

  // downstream memory model: random AR acceptance, beats tagged with sub-burst address and index
  initial forever begin
    @(posedge aclk);
    #1;
    if (!aresetn) begin
      sl_active = 1'b0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rlast   = 1'b0;
    end else begin
      if (r_hs_n) begin
        sl_b++;
        if (sl_b == sl_n) sl_active = 1'b0;
      end
      if (ar_hs_n) begin
        sl_active = 1'b1;
        sl_addr   = snap_addr;
        sl_n      = int'(snap_len) + 1;
        sl_b      = 0;
        m_arready = 1'b0;
      end else m_arready = !sl_active && m_arvalid && $urandom_range(0, 2) == 0;
      if (!sl_active) m_rvalid = 1'b0;
      else if (!m_rvalid || r_hs_n) begin
        if ($urandom_range(0, 3) != 0) begin
          m_rvalid = 1'b1;
          m_rdata  = {sl_addr, 32'(sl_b)};
          m_rresp  = 2'(sl_b);
          m_rlast  = sl_b == sl_n - 1;
          m_rid    = 4'($urandom);
        end else m_rvalid = 1'b0;
      end
    end
  end

  // upstream R consumer: random backpressure plus a forced 3-cycle stall every 40 cycles
  initial forever begin
    @(posedge aclk);
    #1;
    s_rready = (cyc % 40 < 3) ? 1'b0 : $urandom_range(0, 4) != 0;
  end

  initial begin
    repeat (60000) @(posedge aclk);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst);
    int rem;
    int n;
    logic [31:0] a;
    logic [31:0] unit;
    rem  = int'(len) + 1;
    a    = addr;
    unit = 32'd1 << size;
    while (rem > 0) begin
      n = (burst == 2'b01 && rem > 16) ? 16 : rem;
      exp_ar.push_back(128'({id, a, 8'(n - 1), size, burst}));
      for (int b = 0; b < n; b++)
        exp_r.push_back(128'({id, a, 32'(b), 2'(b), rem == n && b == n - 1}));
      a = a - (a % unit) + 32'(n) * unit;
      rem -= n;
    end
  endtask

  task automatic drive_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    s_arid    = id;
    s_araddr  = addr;
    s_arlen   = len;
    s_arsize  = size;
    s_arburst = burst;
    s_arvalid = 1'b1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int i;
    @(posedge aclk);
    #1;
    drive_ar(id, addr, len, size, burst);
    i = 0;
    nstep;
    while (!s_arready && i < 200) begin
      nstep;
      i++;
    end
    if (!s_arready) chk("ar_accept_timeout", 128'(0), 128'(1));
    @(posedge aclk);
    #1;
    s_arvalid = 1'b0;
  endtask

  task automatic wait_rx(input int target);
    int i;
    i = 0;
    while (rx_cnt < target && i < 4000) begin
      nstep;
      i++;
    end
    chk("beat_count", 128'(rx_cnt), 128'(target));
  endtask

  task automatic burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    int base;
    base = rx_cnt;
    expect_burst(id, addr, len, size, burst);
    send_ar(id, addr, len, size, burst);
    wait_rx(base + int'(len) + 1);
    nstep;
    chk("arready_after", 128'(s_arready), 128'(1));
  endtask

  initial begin
    int base, ta, i;
    nstep;
    chk("rst_arready", 128'(s_arready), 128'(0));
    chk("rst_arvalid", 128'(m_arvalid), 128'(0));
    chk("rst_rvalid", 128'(s_rvalid), 128'(0));
    chk("rst_rready", 128'(m_rready), 128'(0));
    chk("rst_payload", 128'({m_araddr, m_arid}), 128'(0));
    #2 aresetn = 1'b1;
    chk("arready_pre_edge", 128'(s_arready), 128'(0));
    nstep;
    chk("arready_first_edge", 128'(s_arready), 128'(1));

    burst(4'h1, 32'h1000, 8'd63, 3'd3, 2'b01);
    burst(4'h2, 32'h1004, 8'd16, 3'd3, 2'b01);
    burst(4'h3, 32'h2000, 8'd4, 3'd2, 2'b01);
    burst(4'h4, 32'h2010, 8'd7, 3'd2, 2'b10);
    burst(4'h5, 32'h2100, 8'd20, 3'd3, 2'b00);
    burst(4'h6, 32'h2200, 8'd20, 3'd1, 2'b11);
    burst(4'h7, 32'hFFFF_FFC0, 8'd40, 3'd3, 2'b01);
    burst(4'h8, 32'h3000, 8'd15, 3'd0, 2'b01);
    burst(4'h9, 32'h3100, 8'd0, 3'd2, 2'b01);

    // second AR arrives while the first is still streaming
    base = rx_cnt;
    expect_burst(4'hA, 32'h3004, 8'd16, 3'd3, 2'b01);
    send_ar(4'hA, 32'h3004, 8'd16, 3'd3, 2'b01);
    ta = base + 17;
    expect_burst(4'hB, 32'h4000, 8'd3, 3'd2, 2'b01);
    drive_ar(4'hB, 32'h4000, 8'd3, 3'd2, 2'b01);
    i = 0;
    nstep;
    while (!s_arready && i < 2000) begin
      nstep;
      i++;
    end
    chk("holdoff_beats", 128'(rx_cnt), 128'(ta));
    chk("holdoff_latency", 128'(cyc - rlast_cyc), 128'(1));
    @(posedge aclk);
    #1;
    s_arvalid = 1'b0;
    wait_rx(ta + 4);

    // reset during the second of four sub-bursts
    base = rx_cnt;
    expect_burst(4'hC, 32'h5000, 8'd63, 3'd3, 2'b01);
    send_ar(4'hC, 32'h5000, 8'd63, 3'd3, 2'b01);
    i = 0;
    while (rx_cnt < base + 20 && i < 2000) begin
      nstep;
      i++;
    end
    chk("rst_reach_sub2", 128'(rx_cnt >= base + 20), 128'(1));
    nstep;
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_arready", 128'(s_arready), 128'(0));
    chk("mid_rst_arvalid", 128'(m_arvalid), 128'(0));
    chk("mid_rst_rvalid", 128'(s_rvalid), 128'(0));
    chk("mid_rst_rready", 128'(m_rready), 128'(0));
    chk("mid_rst_rid", 128'(s_rid), 128'(0));
    exp_ar.delete();
    exp_r.delete();
    repeat (3) begin
      nstep;
      chk("in_rst_arvalid", 128'(m_arvalid), 128'(0));
    end
    aresetn = 1'b1;
    repeat (6) begin
      nstep;
      chk("post_rst_arvalid", 128'(m_arvalid), 128'(0));
      chk("post_rst_arready", 128'(s_arready), 128'(1));
    end
    burst(4'hD, 32'h6000, 8'd31, 3'd3, 2'b01);

    for (int k = 0; k < 25; k++) begin
      logic [2:0] sz;
      logic [1:0] bt;
      sz = 3'($urandom_range(0, 3));
      bt = 2'($urandom_range(0, 3));
      burst(4'($urandom), $urandom, 8'($urandom_range(0, 70)), sz, bt);
    end

    repeat (5) nstep;
    chk("ar_leftover", 128'(exp_ar.size()), 128'(0));
    chk("r_leftover", 128'(exp_r.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
